// File: rtl/rng_pkg.sv
// Shared constants for the rng block: LFSR width, default seed, feedback taps
// and the single-step next-state function for the x^4+x^3+1 polynomial.
package rng_pkg;

  localparam int             RNG_W            = 4;
  localparam logic [RNG_W-1:0] RNG_SEED_DEFAULT = 4'h1;

  // Feedback taps for x^4 + x^3 + 1 (Fibonacci form, shift toward MSB).
  localparam int RNG_TAP_HI = 3;
  localparam int RNG_TAP_LO = 2;

  function automatic logic [RNG_W-1:0] lfsr_next(input logic [RNG_W-1:0] s);
    return {s[RNG_W-2:0], s[RNG_TAP_HI] ^ s[RNG_TAP_LO]};
  endfunction

endpackage

// File: rtl/rng_lfsr.sv
// Free-running maximal-length LFSR (period 15 for 4 bits).
// Ports:
//   clk   - system clock, rising edge
//   rst   - synchronous active-high reset, loads the seed
//   state - current LFSR state
// Only WIDTH = 4 is supported; the taps are fixed for that width.
module rng_lfsr
  import rng_pkg::*;
#(
  parameter int               WIDTH = RNG_W,
  parameter logic [WIDTH-1:0] SEED  = RNG_SEED_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  output logic [WIDTH-1:0] state
);

  // An all-zero seed would lock the register up, so it is replaced by 1.
  localparam logic [WIDTH-1:0] SEED_EFF = (SEED == '0) ? WIDTH'(1) : SEED;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= SEED_EFF;
    end else if (state == '0) begin
      // Unreachable in normal operation; recovers from an upset into 0.
      state <= SEED_EFF;
    end else begin
      state <= lfsr_next(state);
    end
  end

endmodule

// File: rtl/rng.sv
// Pseudo-random number source. A free-running LFSR advances every clock; a
// rising edge on RNG_gen captures the pre-advance LFSR state onto count_out
// and pulses en for one cycle. count_out holds until the next request.
// Ports:
//   clk       - system clock, rising edge
//   rst       - synchronous active-high reset
//   RNG_gen   - request level; a rising edge triggers a capture
//   count_out - last captured value (registered), 0 only after reset
//   en        - one-cycle strobe marking a new count_out (registered)
module rng
  import rng_pkg::*;
#(
  parameter logic [RNG_W-1:0] SEED  = RNG_SEED_DEFAULT,
  parameter int               WIDTH = RNG_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             RNG_gen,
  output logic [WIDTH-1:0] count_out,
  output logic             en
);

  logic [WIDTH-1:0] lfsr;
  logic             gen_q;
  logic             trigger;

  rng_lfsr #(
    .WIDTH (WIDTH),
    .SEED  (SEED)
  ) u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .state (lfsr)
  );

  // gen_q resets high so a request held across reset release is ignored
  // until RNG_gen has been seen low at least once.
  assign trigger = RNG_gen & ~gen_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      gen_q     <= 1'b1;
      count_out <= '0;
      en        <= 1'b0;
    end else begin
      gen_q <= RNG_gen;
      en    <= trigger;
      if (trigger) begin
        // lfsr here is the value before this edge's advance.
        count_out <= lfsr;
      end
    end
  end

endmodule

// File: tb/tb_rng.sv
// Directed self-checking bench for rng.
module tb_rng;

  logic       clk;
  logic       rst;
  logic       RNG_gen;
  logic [3:0] count_out;
  logic       en;
  logic [3:0] count_out0;
  logic       en0;

  int total;
  int bad;
  int k;
  int pre_k;
  logic [3:0] seq [15];

  rng u_dut (
    .clk       (clk),
    .rst       (rst),
    .RNG_gen   (RNG_gen),
    .count_out (count_out),
    .en        (en)
  );

  // Zero seed must be replaced by 1.
  rng #(.SEED(4'h0)) u_dut0 (
    .clk       (clk),
    .rst       (rst),
    .RNG_gen   (RNG_gen),
    .count_out (count_out0),
    .en        (en0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock: drive request, take the edge, sample 1ns later.
  // k counts LFSR advances since the last reset edge.
  task automatic tick(input logic g);
    RNG_gen = g;
    pre_k = k;
    @(posedge clk);
    if (rst) k = 0;
    else k = k + 1;
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(1'b0);
    tick(1'b0);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(1'b0);
    tick(1'b0);
    total++;
    if (count_out !== 4'h0) begin bad++; $display("FAIL reset_count got=%0d want=0", count_out); end
    total++;
    if (en !== 1'b0) begin bad++; $display("FAIL reset_en got=%b want=0", en); end
    total++;
    if (u_dut.u_lfsr.state !== 4'h1) begin bad++; $display("FAIL reset_lfsr got=%0d want=1", u_dut.u_lfsr.state); end
    total++;
    if (u_dut0.u_lfsr.state !== 4'h1) begin bad++; $display("FAIL zero_seed got=%0d want=1", u_dut0.u_lfsr.state); end
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick(1'b0);
      total++;
      if (en !== 1'b0) begin bad++; $display("FAIL idle_en i=%0d got=%b want=0", i, en); end
      total++;
      if (u_dut.u_lfsr.state !== seq[k % 15])
        begin bad++; $display("FAIL lfsr_step i=%0d got=%0d want=%0d", i, u_dut.u_lfsr.state, seq[k % 15]); end
    end
  endtask

  task automatic test_capture();
    do_reset();
    tick(1'b0);
    tick(1'b0);
    tick(1'b0);
    tick(1'b1);
    total++;
    if (en !== 1'b1) begin bad++; $display("FAIL capture_en got=%b want=1", en); end
    total++;
    if (count_out !== 4'd9) begin bad++; $display("FAIL capture_val got=%0d want=9", count_out); end
    for (int i = 0; i < 3; i++) begin
      tick(1'b0);
      total++;
      if (en !== 1'b0) begin bad++; $display("FAIL capture_en_clear i=%0d got=%b want=0", i, en); end
      total++;
      if (count_out !== 4'd9) begin bad++; $display("FAIL capture_hold i=%0d got=%0d want=9", i, count_out); end
    end
  endtask

  task automatic test_held();
    int pulses;
    do_reset();
    tick(1'b0);
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      tick(1'b1);
      if (en === 1'b1) pulses++;
      if (i == 0) begin
        total++;
        if (en !== 1'b1 || count_out !== 4'd2)
          begin bad++; $display("FAIL held_first en=%b val=%0d want en=1 val=2", en, count_out); end
      end
    end
    total++;
    if (pulses != 1) begin bad++; $display("FAIL held_pulses got=%0d want=1", pulses); end
    tick(1'b0);
    total++;
    if (en !== 1'b0) begin bad++; $display("FAIL held_low_en got=%b want=0", en); end
    tick(1'b1);
    total++;
    if (en !== 1'b1 || count_out !== 4'd8)
      begin bad++; $display("FAIL held_second en=%b val=%0d want en=1 val=8", en, count_out); end
  endtask

  task automatic test_spaced();
    logic [3:0] v [3];
    int gaps [3];
    logic [3:0] want [3];
    gaps = '{11, 14, 0};
    want = '{4'd4, 4'd8, 4'd8};
    do_reset();
    tick(1'b0);
    tick(1'b0);
    for (int p = 0; p < 3; p++) begin
      tick(1'b1);
      v[p] = count_out;
      total++;
      if (en !== 1'b1 || count_out !== want[p])
        begin bad++; $display("FAIL spaced_pulse p=%0d en=%b val=%0d want en=1 val=%0d", p, en, count_out, want[p]); end
      for (int i = 0; i < gaps[p]; i++) begin
        tick(1'b0);
        total++;
        if (en !== 1'b0 || count_out !== want[p])
          begin bad++; $display("FAIL spaced_idle p=%0d i=%0d en=%b val=%0d want en=0 val=%0d", p, i, en, count_out, want[p]); end
      end
    end
    total++;
    if (v[0] === v[1]) begin bad++; $display("FAIL spaced_differ got=%0d,%0d want distinct", v[0], v[1]); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 5; i++) tick(1'b0);
    rst = 1'b1;
    tick(1'b1);
    total++;
    if (en !== 1'b0 || count_out !== 4'h0)
      begin bad++; $display("FAIL mid_reset en=%b val=%0d want en=0 val=0", en, count_out); end
    total++;
    if (u_dut.u_lfsr.state !== 4'h1) begin bad++; $display("FAIL mid_reset_lfsr got=%0d want=1", u_dut.u_lfsr.state); end
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick(1'b1);
      total++;
      if (en !== 1'b0 || count_out !== 4'h0)
        begin bad++; $display("FAIL held_release i=%0d en=%b val=%0d want en=0 val=0", i, en, count_out); end
    end
    tick(1'b0);
    tick(1'b1);
    total++;
    if (en !== 1'b1 || count_out !== 4'd6)
      begin bad++; $display("FAIL rearm en=%b val=%0d want en=1 val=6", en, count_out); end
  endtask

  task automatic test_period();
    logic [3:0] st [30];
    logic g;
    do_reset();
    for (int i = 0; i < 30; i++) begin
      g = (i % 2 == 1);
      tick(g);
      st[i] = u_dut.u_lfsr.state;
      if (g) begin
        total++;
        if (en !== 1'b1 || count_out === 4'h0 || count_out !== seq[pre_k % 15])
          begin bad++; $display("FAIL period_cap i=%0d en=%b val=%0d want en=1 val=%0d", i, en, count_out, seq[pre_k % 15]); end
      end
    end
    for (int i = 0; i < 15; i++) begin
      total++;
      if (st[i] === 4'h0 || st[i] !== st[i + 15])
        begin bad++; $display("FAIL period_repeat i=%0d got=%0d,%0d want equal nonzero", i, st[i], st[i + 15]); end
    end
  endtask

  initial begin
    seq = '{4'd1, 4'd2, 4'd4, 4'd9, 4'd3, 4'd6, 4'd13, 4'd10,
            4'd5, 4'd11, 4'd7, 4'd15, 4'd14, 4'd12, 4'd8};
    total   = 0;
    bad     = 0;
    k       = 0;
    pre_k   = 0;
    rst     = 1'b1;
    RNG_gen = 1'b0;
    test_reset();
    test_capture();
    test_held();
    test_spaced();
    test_reset_mid();
    test_period();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
